// File: rtl/nes_pkg.sv
// Shared NES pad definitions: button bit positions, sequencer/FSM states,
// and the duplicated-byte word format used on the Ethernet link.
package nes_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_UPDATE,
        ST_TX
    } nes_state_e;

    // Receiver only accepts a word whose two bytes agree.
    function automatic logic [15:0] pack_word(input logic [7:0] btn);
        return {btn, btn};
    endfunction

endpackage

// File: rtl/nes_shift_timer.sv
// Latch/pulse sequencer for one NES pad scan: latch, then 8 samples taken at
// the end of each pulse-low phase (7 pulses between them).
module nes_shift_timer
    import nes_pkg::*;
#(
    parameter int LATCH_CYCLES = 600,
    parameter int HALF_CYCLES  = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic       i_sync_data,
    output logic       o_latch,
    output logic       o_pulse,
    output logic       o_done,
    output logic [7:0] o_shift
);

    localparam int MAXC = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    nes_state_e     r_state, w_next;
    logic [CW-1:0]  r_cnt;
    logic [2:0]     r_k;
    logic [7:0]     r_shift;
    logic           w_last_latch, w_last_half;

    assign w_last_latch = (r_cnt == CW'(LATCH_CYCLES - 1));
    assign w_last_half  = (r_cnt == CW'(HALF_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (i_start) w_next = ST_LATCH;
            ST_LATCH: if (w_last_latch) w_next = ST_LOW;
            ST_LOW:   if (w_last_half) w_next = (r_k == 3'd7) ? ST_IDLE : ST_HIGH;
            ST_HIGH:  if (w_last_half) w_next = ST_LOW;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_k     <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_LATCH: r_cnt <= w_last_latch ? '0 : r_cnt + CW'(1);
                ST_LOW: begin
                    if (w_last_half) begin
                        // Pad data is active-low; store pressed as 1.
                        r_shift[r_k] <= ~i_sync_data;
                        r_cnt        <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_HIGH: begin
                    if (w_last_half) begin
                        r_k   <= r_k + 3'd1;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                    r_k   <= '0;
                end
            endcase
        end
    end

    assign o_latch = (r_state == ST_LATCH);
    assign o_pulse = (r_state == ST_HIGH);
    assign o_done  = (r_state == ST_LOW) && w_last_half && (r_k == 3'd7);
    assign o_shift = r_shift;

endmodule

// File: rtl/nes_controller_reader.sv
// Polls an NES pad, detects changes (with keepalive) and streams
// duplicated-byte words to the Ethernet transmit stack.
module nes_controller_reader
    import nes_pkg::*;
#(
    parameter int POLL_CYCLES     = 833_333,
    parameter int LATCH_CYCLES    = 600,
    parameter int HALF_CYCLES     = 300,
    parameter int WORDS           = 8,
    parameter int KEEPALIVE_POLLS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_in,
    output logic        latch,
    output logic        pulse,
    output logic [7:0]  buttons,
    output logic        axiov,
    output logic [15:0] axiod,
    output logic [7:0]  pkt_count
);

    localparam int PW = $clog2(POLL_CYCLES);
    localparam int QW = $clog2(KEEPALIVE_POLLS) + 1;
    localparam int WW = $clog2(WORDS) + 1;

    nes_state_e     r_state, w_next;
    logic [1:0]     r_sync;
    logic [PW-1:0]  r_poll;
    logic           r_pending, r_force;
    logic [7:0]     r_last, r_buttons, r_pkt;
    logic [QW-1:0]  r_quiet;
    logic [WW-1:0]  r_word;
    logic           r_axiov;
    logic [15:0]    r_axiod;
    logic           w_tick, w_start, w_done, w_send;
    logic [7:0]     w_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_sync <= '0;
        else      r_sync <= {r_sync[0], data_in};
    end

    assign w_tick = (r_poll == PW'(POLL_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)        r_poll <= '0;
        else if (w_tick) r_poll <= '0;
        else             r_poll <= r_poll + PW'(1);
    end

    nes_shift_timer #(
        .LATCH_CYCLES (LATCH_CYCLES),
        .HALF_CYCLES  (HALF_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst_n       (rst),
        .i_start     (w_start),
        .i_sync_data (r_sync[1]),
        .o_latch     (latch),
        .o_pulse     (pulse),
        .o_done      (w_done),
        .o_shift     (w_shift)
    );

    assign w_send = r_force || (w_shift != r_last) ||
                    (r_quiet == QW'(KEEPALIVE_POLLS - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    // ST_LATCH here covers the whole scan; the sub-sequencer owns its phases.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick || r_pending) begin
                    w_next  = ST_LATCH;
                    w_start = 1'b1;
                end
            end
            ST_LATCH:  if (w_done) w_next = ST_UPDATE;
            ST_UPDATE: w_next = w_send ? ST_TX : ST_IDLE;
            ST_TX:     if (r_word == WW'(WORDS - 1)) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // A single pending tick is remembered while busy; extra ticks are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                               r_pending <= 1'b0;
        else if (w_start)                       r_pending <= 1'b0;
        else if (w_tick && r_state != ST_IDLE)  r_pending <= 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_force   <= 1'b1;
            r_last    <= '0;
            r_buttons <= '0;
            r_quiet   <= '0;
            r_word    <= '0;
            r_axiov   <= 1'b0;
            r_axiod   <= '0;
            r_pkt     <= '0;
        end else begin
            case (r_state)
                ST_UPDATE: begin
                    r_buttons <= w_shift;
                    if (w_send) begin
                        r_last  <= w_shift;
                        r_quiet <= '0;
                        r_force <= 1'b0;
                        r_word  <= '0;
                        r_axiov <= 1'b1;
                        r_axiod <= pack_word(w_shift);
                    end else begin
                        r_quiet <= r_quiet + QW'(1);
                    end
                end
                ST_TX: begin
                    if (r_word == WW'(WORDS - 1)) begin
                        r_axiov <= 1'b0;
                        r_axiod <= '0;
                        r_pkt   <= r_pkt + 8'd1;
                    end else begin
                        r_word <= r_word + WW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign buttons   = r_buttons;
    assign axiov     = r_axiov;
    assign axiod     = r_axiod;
    assign pkt_count = r_pkt;

endmodule

// File: tb/tb_nes_controller_reader.sv
// Bench for nes_controller_reader: pad model, scan-level reference model,
// burst scoreboard and latch/pulse protocol monitor.
module tb_nes_controller_reader;

    localparam int POLL  = 200;
    localparam int LAT   = 12;
    localparam int HALF  = 6;
    localparam int WORDS = 4;
    localparam int KA    = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_in;
    logic        latch, pulse, axiov;
    logic [7:0]  buttons, pkt_count;
    logic [15:0] axiod;

    always #5 clk = ~clk;

    nes_controller_reader #(
        .POLL_CYCLES     (POLL),
        .LATCH_CYCLES    (LAT),
        .HALF_CYCLES     (HALF),
        .WORDS           (WORDS),
        .KEEPALIVE_POLLS (KA)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .latch     (latch),
        .pulse     (pulse),
        .buttons   (buttons),
        .axiov     (axiov),
        .axiod     (axiod),
        .pkt_count (pkt_count)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Pad: parallel-load on latch, next bit on each pulse rise, 0 = pressed.
    logic [7:0] pad_btn  = 8'h00;
    logic [7:0] pad_snap = 8'h00;
    int         pad_idx  = 0;

    always @(posedge latch or posedge pulse) begin
        if (latch) begin
            pad_snap = pad_btn;
            pad_idx  = 0;
        end else begin
            pad_idx++;
        end
    end

    assign data_in = (pad_idx < 8) ? ~pad_snap[pad_idx[2:0]] : 1'b0;

    // Reference model works per scan: what the pad held decides the burst.
    typedef struct packed {
        logic [15:0] word;
        logic [7:0]  pkt;
    } burst_t;

    burst_t     exp_q[$];
    logic [7:0] m_last, m_btn, m_pkt, m_v;
    bit         m_force;
    int         m_quiet;
    int         cyc, run, lat_run, hi_run, lo_run, npulse;
    bit         prev_latch, prev_pulse, prev_axiov, have_scan;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_last = 8'h00; m_btn = 8'h00; m_pkt = 8'h00; m_force = 1'b1; m_quiet = 0;
            cyc = 0; run = 0; lat_run = 0; hi_run = 0; lo_run = 0; npulse = 0;
            prev_latch = 0; prev_pulse = 0; prev_axiov = 0; have_scan = 0;
        end else begin
            cyc++;
            check("latch_pulse_overlap", {31'd0, latch & pulse}, 32'd0);

            if (latch && !prev_latch) begin
                check("scan_start_cycle", cyc % POLL, 0);
                check("buttons_before_scan", buttons, m_btn);
                check("bursts_outstanding", exp_q.size(), 0);
                if (have_scan) check("pulses_per_scan", npulse, 7);
                have_scan = 1; npulse = 0; lat_run = 0;
                m_v   = pad_btn;
                m_btn = m_v;
                if (m_force || m_v != m_last || m_quiet == KA - 1) begin
                    m_force = 0; m_last = m_v; m_quiet = 0; m_pkt++;
                    exp_q.push_back('{word: {m_v, m_v}, pkt: m_pkt});
                end else begin
                    m_quiet++;
                end
            end
            if (latch) lat_run++;
            if (!latch && prev_latch) begin
                check("latch_width", lat_run, LAT);
                lo_run = 0;
            end
            if (pulse && !prev_pulse) begin
                check("pulse_low_width", lo_run, HALF);
                npulse++;
                hi_run = 0;
            end
            if (pulse) hi_run++;
            if (!pulse && prev_pulse) begin
                check("pulse_high_width", hi_run, HALF);
                lo_run = 0;
            end
            if (!latch && !pulse) lo_run++;

            if (axiov) begin
                run++;
                check("burst_length_max", {31'd0, run <= WORDS}, 32'd1);
                if (exp_q.size() == 0) check("word_unexpected", exp_q.size(), 1);
                else                   check("word", axiod, exp_q[0].word);
            end else if (prev_axiov) begin
                check("burst_length", run, WORDS);
                if (exp_q.size() > 0) begin
                    check("pkt_count", pkt_count, exp_q[0].pkt);
                    void'(exp_q.pop_front());
                end
                run = 0;
            end
            prev_latch = latch; prev_pulse = pulse; prev_axiov = axiov;
        end
    end

    task automatic next_scan(input logic [7:0] v);
        pad_btn = v;
        repeat (POLL) @(negedge clk);
    endtask

    logic [7:0] prev_v;
    logic [7:0] nv;

    initial begin
        rst = 1'b0;
        pad_btn = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check("rst_latch", latch, 0);
        check("rst_pulse", pulse, 0);
        check("rst_axiov", axiov, 0);
        check("rst_axiod", axiod, 0);
        check("rst_buttons", buttons, 0);
        check("rst_pkt", pkt_count, 0);
        @(negedge clk); #1 rst = 1'b1;

        // Scan 1 forced burst of zeros; then A+Start and keepalive.
        repeat (350) @(negedge clk);
        next_scan(8'h09);
        repeat (3) next_scan(8'h09);
        for (int i = 0; i < 3; i++) begin
            next_scan(8'h80);
            next_scan(8'h40);
        end

        // Change to nothing-pressed, then reset during the 2nd word.
        pad_btn = 8'h00;
        for (int i = 0; i < 400 && !axiov; i++) @(negedge clk);
        check("burst_before_reset_seen", axiov, 1);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_axiov", axiov, 0);
        check("async_rst_axiod", axiod, 0);
        check("async_rst_latch", latch, 0);
        check("async_rst_pulse", pulse, 0);
        check("async_rst_pkt", pkt_count, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;

        // Unchanged pad after reset still yields a forced burst; then
        // always-changing pad drives pkt_count through its wrap.
        repeat (350) @(negedge clk);
        prev_v = 8'h00;
        for (int i = 0; i < 257; i++) begin
            nv = prev_v ^ 8'($urandom_range(1, 255));
            next_scan(nv);
            prev_v = nv;
        end
        repeat (POLL) @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        check("final_buttons", buttons, m_btn);
        check("final_pkt", pkt_count, m_pkt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
